// File: rtl/a0_capture_fifo_if.sv
// Bundles the a0 capture inputs and the valid/ready drain stream of a0_capture_fifo.
// The out_ts signal exists only when A0_CAPTURE_TS_EN is defined.
interface a0_capture_fifo_if #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8,
    parameter int TS_WIDTH   = 16
);
    logic [DATA_WIDTH-1:0]    a0_in;
    logic                     capture_en;
    logic [DATA_WIDTH-1:0]    out_data;
    logic                     out_valid;
    logic                     out_ready;
    logic [$clog2(DEPTH):0]   count;
    logic                     overflow;
    logic                     clear_ovf;
`ifdef A0_CAPTURE_TS_EN
    logic [TS_WIDTH-1:0]      out_ts;
`endif

    if (TS_WIDTH < 1) begin : g_bad_ts_width
        $error("a0_capture_fifo_if: TS_WIDTH must be at least 1");
    end

    modport master (
        output a0_in, capture_en, out_ready, clear_ovf,
        input  out_data, out_valid, count, overflow
`ifdef A0_CAPTURE_TS_EN
        , input out_ts
`endif
    );

    modport slave (
        input  a0_in, capture_en, out_ready, clear_ovf,
        output out_data, out_valid, count, overflow
`ifdef A0_CAPTURE_TS_EN
        , output out_ts
`endif
    );
endinterface

// File: rtl/a0_capture_fifo.sv
// Captures every change of the core's a0 output into a first-word-fall-through FIFO.
// Define A0_CAPTURE_TS_EN to stamp each entry with a free-running cycle count (out_ts).
module a0_capture_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8,
    parameter int TS_WIDTH   = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    a0_capture_fifo_if.slave   bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TS_WIDTH < 1) begin : g_bad_params
        $error("a0_capture_fifo: DEPTH must be a power of 2 >= 2 and TS_WIDTH >= 1");
    end

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] last_a0_q, last_a0_d;
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  ovf_q, ovf_d;

    logic chg, not_empty, pop, push_ok, drop;

    always_comb begin
        chg       = bus.capture_en && (bus.a0_in != last_a0_q);
        not_empty = (count_q != '0);
        pop       = not_empty && bus.out_ready;
        // A full FIFO still takes a push when the head leaves in the same cycle
        push_ok   = chg && ((count_q < CW'(DEPTH)) || pop);
        drop      = chg && !push_ok;

        last_a0_d = bus.capture_en ? bus.a0_in : last_a0_q;
        wr_ptr_d  = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d  = pop     ? rd_ptr_q + AW'(1) : rd_ptr_q;

        count_d = count_q;
        unique case ({push_ok, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        ovf_d = ovf_q;
        if (drop)               ovf_d = 1'b1;
        else if (bus.clear_ovf) ovf_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_a0_q <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
        end else begin
            last_a0_q <= last_a0_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            ovf_q     <= ovf_d;
        end
    end

    // Storage is not reset; out_valid gates anything stale
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= bus.a0_in;
    end

    assign bus.out_valid = not_empty;
    assign bus.out_data  = not_empty ? mem_q[rd_ptr_q] : '0;
    assign bus.count     = count_q;
    assign bus.overflow  = ovf_q;

`ifdef A0_CAPTURE_TS_EN
    logic [TS_WIDTH-1:0] ts_q;
    logic [TS_WIDTH-1:0] ts_mem_q [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ts_q <= '0;
        else        ts_q <= ts_q + TS_WIDTH'(1);
    end

    always_ff @(posedge clk) begin
        if (push_ok) ts_mem_q[wr_ptr_q] <= ts_q;
    end

    assign bus.out_ts = not_empty ? ts_mem_q[rd_ptr_q] : '0;
`endif
endmodule

// File: tb/tb_a0_capture_fifo.sv
// Self-checking bench for a0_capture_fifo: vector table, directed corner sequences,
// and randomized traffic against a queue-based reference model.
module tb_a0_capture_fifo;
    localparam int DW    = 32;
    localparam int DEPTH = 8;
    localparam int TSW   = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   nvec = 0;
    int   nerr = 0;

    always #5 clk = ~clk;

    a0_capture_fifo_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .TS_WIDTH(TSW)) bus ();

    a0_capture_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .TS_WIDTH(TSW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Reference model: a plain queue of captured values
    logic [DW-1:0] mq [$];
    logic [DW-1:0] m_last;
    logic          m_ovf;
`ifdef A0_CAPTURE_TS_EN
    logic [TSW-1:0] tq [$];
    logic [TSW-1:0] m_tcnt;
`endif

    function automatic void chk(string nm, longint unsigned act, longint unsigned exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endfunction

    function automatic void model_reset();
        mq.delete();
        m_last = '0;
        m_ovf  = 1'b0;
`ifdef A0_CAPTURE_TS_EN
        tq.delete();
        m_tcnt = '0;
`endif
    endfunction

    function automatic void model_step();
        logic          chg;
        logic          pop;
        logic [DW-1:0] tmp;
`ifdef A0_CAPTURE_TS_EN
        logic [TSW-1:0] tts;
`endif
        if (!rst_n) return;
        chg = bus.capture_en && (bus.a0_in != m_last);
        pop = (mq.size() != 0) && bus.out_ready;
        if (bus.capture_en) m_last = bus.a0_in;
        if (pop) begin
            tmp = mq.pop_front();
`ifdef A0_CAPTURE_TS_EN
            tts = tq.pop_front();
`endif
        end
        if (bus.clear_ovf) m_ovf = 1'b0;
        if (chg) begin
            if (mq.size() < DEPTH) begin
                mq.push_back(bus.a0_in);
`ifdef A0_CAPTURE_TS_EN
                tq.push_back(m_tcnt);
`endif
            end else begin
                m_ovf = 1'b1;
            end
        end
`ifdef A0_CAPTURE_TS_EN
        m_tcnt = m_tcnt + 1'b1;
`endif
    endfunction

    function automatic void check_all();
        chk("out_valid", bus.out_valid, (mq.size() != 0) ? 1 : 0);
        chk("out_data",  bus.out_data,  (mq.size() != 0) ? mq[0] : 0);
        chk("count",     bus.count,     mq.size());
        chk("overflow",  bus.overflow,  m_ovf);
`ifdef A0_CAPTURE_TS_EN
        chk("out_ts",    bus.out_ts,    (tq.size() != 0) ? tq[0] : 0);
`endif
    endfunction

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic do_reset();
        rst_n          = 1'b0;
        bus.a0_in      = '0;
        bus.capture_en = 1'b1;
        bus.out_ready  = 1'b0;
        bus.clear_ovf  = 1'b0;
        model_reset();
        #1;
        check_all();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic [DW-1:0] a0;
        logic          en;
        logic          rdy;
        logic          clr;
        int            cnt;
        logic          vld;
        logic [DW-1:0] data;
        logic          ovf;
    } vec_t;

    vec_t tbl [9];

    initial begin
        bus.a0_in      = '0;
        bus.capture_en = 1'b0;
        bus.out_ready  = 1'b0;
        bus.clear_ovf  = 1'b0;

        // a0 pattern 5,5,9,7 with stalled sink, then drain
        tbl[0] = '{32'd5, 1'b1, 1'b0, 1'b0, 1, 1'b1, 32'd5, 1'b0};
        tbl[1] = '{32'd5, 1'b1, 1'b0, 1'b0, 1, 1'b1, 32'd5, 1'b0};
        tbl[2] = '{32'd9, 1'b1, 1'b0, 1'b0, 2, 1'b1, 32'd5, 1'b0};
        tbl[3] = '{32'd7, 1'b1, 1'b0, 1'b0, 3, 1'b1, 32'd5, 1'b0};
        tbl[4] = '{32'd7, 1'b1, 1'b0, 1'b0, 3, 1'b1, 32'd5, 1'b0};
        tbl[5] = '{32'd7, 1'b1, 1'b1, 1'b0, 2, 1'b1, 32'd9, 1'b0};
        tbl[6] = '{32'd7, 1'b1, 1'b1, 1'b0, 1, 1'b1, 32'd7, 1'b0};
        tbl[7] = '{32'd7, 1'b1, 1'b1, 1'b0, 0, 1'b0, 32'd0, 1'b0};
        tbl[8] = '{32'd7, 1'b1, 1'b1, 1'b0, 0, 1'b0, 32'd0, 1'b0};

        // a0 held at 0 after reset never pushes
        do_reset();
        repeat (10) tick();
        chk("idle_valid", bus.out_valid, 0);
        chk("idle_count", bus.count, 0);
        chk("idle_ovf",   bus.overflow, 0);

        do_reset();
        for (int i = 0; i < 9; i++) begin
            bus.a0_in      = tbl[i].a0;
            bus.capture_en = tbl[i].en;
            bus.out_ready  = tbl[i].rdy;
            bus.clear_ovf  = tbl[i].clr;
            tick();
            chk("tbl_count", bus.count,     tbl[i].cnt);
            chk("tbl_valid", bus.out_valid, tbl[i].vld);
            chk("tbl_data",  bus.out_data,  tbl[i].data);
            chk("tbl_ovf",   bus.overflow,  tbl[i].ovf);
        end

        // Nine distinct values into eight entries
        do_reset();
        for (int v = 1; v <= 9; v++) begin
            bus.a0_in = DW'(v);
            tick();
        end
        chk("full_count", bus.count, 8);
        chk("full_ovf",   bus.overflow, 1);
        bus.out_ready = 1'b1;
        for (int v = 1; v <= 8; v++) begin
            chk("drain_data", bus.out_data, v);
            tick();
        end
        chk("drained_count", bus.count, 0);
        chk("ovf_sticky", bus.overflow, 1);
        bus.clear_ovf = 1'b1;
        tick();
        bus.clear_ovf = 1'b0;
        chk("ovf_cleared", bus.overflow, 0);

        // Drop in the same cycle as clear_ovf: the set wins
        do_reset();
        for (int v = 1; v <= 8; v++) begin
            bus.a0_in = DW'(v);
            tick();
        end
        bus.a0_in     = 32'd100;
        bus.clear_ovf = 1'b1;
        tick();
        bus.clear_ovf = 1'b0;
        chk("drop_beats_clear", bus.overflow, 1);

        // Push into a full FIFO while popping
        do_reset();
        for (int v = 1; v <= 8; v++) begin
            bus.a0_in = DW'(v);
            tick();
        end
        bus.a0_in     = 32'hAA;
        bus.out_ready = 1'b1;
        tick();
        chk("fullpop_count", bus.count, 8);
        chk("fullpop_ovf",   bus.overflow, 0);
        for (int i = 0; i < 8; i++) begin
            chk("fullpop_data", bus.out_data, (i == 7) ? 32'hAA : 32'(i + 2));
            tick();
        end
        chk("fullpop_empty", bus.out_valid, 0);

        // capture_en gating, then asynchronous reset mid-drain
        do_reset();
        bus.capture_en = 1'b0;
        bus.a0_in = 32'd3;
        tick();
        bus.a0_in = 32'd4;
        tick();
        chk("gated_count", bus.count, 0);
        bus.capture_en = 1'b1;
        tick();
        chk("en_count", bus.count, 1);
        chk("en_data",  bus.out_data, 4);
        bus.a0_in = 32'd6;
        tick();
        bus.out_ready = 1'b1;
        tick();
        chk("middrain_data", bus.out_data, 6);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("async_rst_valid", bus.out_valid, 0);
        chk("async_rst_count", bus.count, 0);
        check_all();
        tick();
        rst_n = 1'b1;

        // Randomized traffic against the model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            bus.a0_in      = DW'($urandom_range(0, 5));
            bus.capture_en = ($urandom_range(0, 9) < 8);
            bus.out_ready  = ($urandom_range(0, 9) < ((i / 500) % 2 == 0 ? 3 : 7));
            bus.clear_ovf  = ($urandom_range(0, 19) == 0);
            tick();
        end

`ifdef A0_CAPTURE_TS_EN
        do_reset();
        repeat (10) tick();
        bus.a0_in = 32'd11;
        tick();
        chk("ts_first", bus.out_ts, 10);
        repeat (14) tick();
        bus.a0_in = 32'd22;
        tick();
        bus.out_ready = 1'b1;
        tick();
        chk("ts_second", bus.out_ts, 25);
        do_reset();
        repeat (65540) tick();
        bus.a0_in = 32'd1;
        tick();
        chk("ts_wrap", bus.out_ts, 4);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
